// File: rtl/hcp_tsmp_parser.sv
// TSMP host-command parser: header capture, then register writes from packed payload words or read requests.
// Latency: o_wr / o_rd_req / o_err / o_busy all registered, one cycle after the causing beat or ack.
// Backpressure: none on the byte stream; reads hold o_rd_req until i_rd_ack. Optional macro: HCP_PARSER_ERR_CNT_EN.
module hcp_tsmp_parser #(
    parameter int DATA_WIDTH = 9,
    parameter int HDR_LEN    = 24,
    parameter int TYPE_IDX   = 1,
    parameter int CNT_IDX    = 18,
    parameter int ADDR_W     = 6,
    parameter int WORD_BYTES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   iv_data,
    input  logic                    i_data_wr,
    output logic                    o_wr,
    output logic [ADDR_W-1:0]       ov_wr_addr,
    output logic [8*WORD_BYTES-1:0] ov_wr_data,
    output logic                    o_rd_req,
    output logic [ADDR_W-1:0]       ov_rd_addr,
    input  logic                    i_rd_ack,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [15:0]             ov_err_cnt
);
    localparam int WW = 8*WORD_BYTES;
    localparam int HW = $clog2(HDR_LEN);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_WRITE, S_READ, S_DROP} state_t;

    state_t            state;
    logic [HW-1:0]     hdr_cnt;
    logic [7:0]        typ_q;
    logic [7:0]        cnt_q;
    logic [7:0]        words_left;
    logic [ADDR_W-1:0] addr;
    logic [WW-1:0]     word_q;
    logic [1:0]        byte_idx;

    logic              start;
    logic [7:0]        beat_byte;
    logic [7:0]        hdr_type;
    logic [7:0]        hdr_count;
    logic [WW+7:0]     word_cat;
    logic [WW-1:0]     word_nxt;
    logic              last_hdr;
    logic              last_byte;

    // Type/count are taken from the live byte when they sit in the final header byte.
    always_comb begin
        start     = i_data_wr & iv_data[DATA_WIDTH-1];
        beat_byte = iv_data[7:0];
        hdr_type  = (hdr_cnt == HW'(TYPE_IDX)) ? beat_byte : typ_q;
        hdr_count = (hdr_cnt == HW'(CNT_IDX))  ? beat_byte : cnt_q;
        word_cat  = {word_q, beat_byte};
        word_nxt  = word_cat[WW-1:0];
        last_hdr  = (hdr_cnt == HW'(HDR_LEN-1));
        last_byte = (byte_idx == 2'(WORD_BYTES-1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            hdr_cnt    <= '0;
            typ_q      <= '0;
            cnt_q      <= '0;
            words_left <= '0;
            addr       <= '0;
            word_q     <= '0;
            byte_idx   <= '0;
            o_wr       <= 1'b0;
            ov_wr_addr <= '0;
            ov_wr_data <= '0;
            o_rd_req   <= 1'b0;
            ov_rd_addr <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_wr  <= 1'b0;
            o_err <= 1'b0;
            if (start) begin
                // A start byte always opens a new header; it is an error only if a packet was live.
                o_err    <= (state == S_HDR) || (state == S_WRITE) || (state == S_READ);
                state    <= S_HDR;
                o_busy   <= 1'b1;
                hdr_cnt  <= HW'(1);
                byte_idx <= '0;
                o_rd_req <= 1'b0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (i_data_wr) begin
                            if (hdr_cnt == HW'(TYPE_IDX)) typ_q <= beat_byte;
                            if (hdr_cnt == HW'(CNT_IDX))  cnt_q <= beat_byte;
                            if (last_hdr) begin
                                addr       <= beat_byte[ADDR_W-1:0];
                                words_left <= hdr_count;
                                byte_idx   <= '0;
                                if ((hdr_type == 8'h01 || hdr_type == 8'h00) && hdr_count == 8'd0) begin
                                    state  <= S_IDLE;
                                    o_busy <= 1'b0;
                                end else if (hdr_type == 8'h01) begin
                                    state <= S_WRITE;
                                end else if (hdr_type == 8'h00) begin
                                    state      <= S_READ;
                                    o_rd_req   <= 1'b1;
                                    ov_rd_addr <= beat_byte[ADDR_W-1:0];
                                end else begin
                                    state <= S_DROP;
                                end
                            end else begin
                                hdr_cnt <= hdr_cnt + HW'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        if (i_data_wr) begin
                            word_q   <= word_nxt;
                            byte_idx <= byte_idx + 2'd1;
                            if (last_byte) begin
                                o_wr       <= 1'b1;
                                ov_wr_addr <= addr;
                                ov_wr_data <= word_nxt;
                                addr       <= addr + ADDR_W'(1);
                                words_left <= words_left - 8'd1;
                                byte_idx   <= '0;
                                if (words_left == 8'd1) begin
                                    state  <= S_IDLE;
                                    o_busy <= 1'b0;
                                end
                            end
                        end
                    end
                    S_READ: begin
                        // One idle cycle follows every ack, so requests issue at most every other cycle.
                        if (o_rd_req && i_rd_ack) begin
                            o_rd_req   <= 1'b0;
                            addr       <= addr + ADDR_W'(1);
                            words_left <= words_left - 8'd1;
                            if (words_left == 8'd1) begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end
                        end else if (!o_rd_req) begin
                            o_rd_req   <= 1'b1;
                            ov_rd_addr <= addr;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef HCP_PARSER_ERR_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_err_cnt <= '0;
        end else if (o_err && ov_err_cnt != 16'hFFFF) begin
            ov_err_cnt <= ov_err_cnt + 16'd1;
        end
    end
`else
    assign ov_err_cnt = '0;
`endif

endmodule

// File: tb/tb_hcp_tsmp_parser.sv
// Randomized bench for hcp_tsmp_parser with a packet-level reference model and scoreboards.
module tb_hcp_tsmp_parser;
    localparam int HDR_LEN  = 24;
    localparam int TYPE_IDX = 1;
    localparam int CNT_IDX  = 18;
    localparam int WB       = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [8:0]  iv_data = '0;
    logic        i_data_wr = 1'b0;
    logic        i_rd_ack = 1'b0;
    logic        o_wr;
    logic [5:0]  ov_wr_addr;
    logic [31:0] ov_wr_data;
    logic        o_rd_req;
    logic [5:0]  ov_rd_addr;
    logic        o_busy;
    logic        o_err;
    logic [15:0] ov_err_cnt;

    hcp_tsmp_parser dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_data(iv_data), .i_data_wr(i_data_wr),
        .o_wr(o_wr), .ov_wr_addr(ov_wr_addr), .ov_wr_data(ov_wr_data),
        .o_rd_req(o_rd_req), .ov_rd_addr(ov_rd_addr), .i_rd_ack(i_rd_ack),
        .o_busy(o_busy), .o_err(o_err), .ov_err_cnt(ov_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;

    int         n_checks = 0;
    int         n_errors = 0;
    wr_t        exp_wr[$];
    logic [5:0] exp_rd[$];
    int         exp_err = 0;
    int         obs_err = 0;
    bit         pending_err = 0;
    bit         exp_busy = 0;
    int         ack_delay = -1;
    logic [7:0] pay[0:63];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Write-strobe scoreboard and error-pulse counter.
    initial forever begin
        @(negedge i_clk);
        if (i_rst_n) begin
            if (o_err) obs_err++;
            if (o_wr) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", ov_wr_addr, e.a);
                    chk("wr_data", ov_wr_data, e.d);
                end
            end
        end
    end

    // Read responder: checks each presented address, acks after a delay.
    initial forever begin
        int d;
        @(negedge i_clk);
        if (i_rst_n && o_rd_req) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", ov_rd_addr, exp_rd.pop_front());
            d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            repeat (d) @(negedge i_clk);
            i_rd_ack = 1'b1;
            @(negedge i_clk);
            i_rd_ack = 1'b0;
        end
    end

    task automatic beat(input logic [8:0] v, input int gapm);
        int g;
        iv_data   = v;
        i_data_wr = 1'b1;
        @(negedge i_clk);
        i_data_wr = 1'b0;
        iv_data   = 9'($urandom);
        g = (gapm == 1) ? 1 : (gapm == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) @(negedge i_clk);
    endtask

    // Builds one packet, predicts its effect from the packet rules, then streams it.
    task automatic send_pkt(input logic [7:0] typ, input int cnt, input logic [5:0] base,
                            input int trunc, input int gapm, input bit use_pay);
        logic [7:0] pk[$];
        int len, sent, npay;
        npay = (typ == 8'h01) ? cnt*WB : (typ == 8'h00) ? 0 : int'($urandom_range(0, 6));
        len  = HDR_LEN + npay;
        for (int i = 0; i < HDR_LEN; i++) pk.push_back(8'($urandom));
        pk[TYPE_IDX]   = typ;
        pk[CNT_IDX]    = 8'(cnt);
        pk[HDR_LEN-1]  = {pk[HDR_LEN-1][7:6], base};
        for (int i = 0; i < npay; i++) pk.push_back((use_pay && i < 64) ? pay[i] : 8'($urandom));
        sent = (trunc > 0 && trunc < len) ? trunc : len;

        if (pending_err) exp_err++;
        if (typ == 8'h01)
            for (int w = 0; w < cnt; w++)
                if (sent >= HDR_LEN + WB*(w+1)) begin
                    wr_t e;
                    int o;
                    o = HDR_LEN + WB*w;
                    e.a = 6'((int'(base) + w) % 64);
                    e.d = {pk[o], pk[o+1], pk[o+2], pk[o+3]};
                    exp_wr.push_back(e);
                end
        if (typ == 8'h00 && sent >= HDR_LEN)
            for (int r = 0; r < cnt; r++) exp_rd.push_back(6'((int'(base) + r) % 64));
        pending_err = (sent < HDR_LEN) || (typ == 8'h01 && cnt > 0 && sent < len);
        exp_busy    = pending_err || (sent >= HDR_LEN && typ != 8'h00 && typ != 8'h01);

        for (int j = 0; j < sent; j++) beat({j == 0, pk[j]}, gapm);

        if (typ == 8'h00 && sent >= HDR_LEN && cnt > 0) begin
            int t;
            t = 0;
            while ((exp_rd.size() != 0 || o_rd_req) && t < 400) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 400) chk("rd_timeout", 0, 1);
            chk("rd_req_done", o_rd_req, 0);
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (3) @(negedge i_clk);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_err_pulses"}, obs_err, exp_err);
`ifdef HCP_PARSER_ERR_CNT_EN
        chk({tag, "_err_cnt"}, ov_err_cnt, (exp_err > 65535) ? 65535 : exp_err);
`else
        chk({tag, "_err_cnt"}, ov_err_cnt, 0);
`endif
        chk({tag, "_busy"}, o_busy, exp_busy);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_wr", o_wr, 0);
        chk("rst_wr_addr", ov_wr_addr, 0);
        chk("rst_wr_data", ov_wr_data, 0);
        chk("rst_rd_req", o_rd_req, 0);
        chk("rst_rd_addr", ov_rd_addr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_err_cnt", ov_err_cnt, 0);
        exp_wr.delete();
        exp_rd.delete();
        exp_err = 0;
        obs_err = 0;
        pending_err = 0;
        exp_busy = 0;
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        logic [7:0] demo[0:7];
        demo = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 8; i++) pay[i] = demo[i];
        @(negedge i_clk);
        do_reset();

        send_pkt(8'h01, 2, 6'h05, 0, 0, 1);
        checkpoint("wr_basic");
        ack_delay = 1;
        send_pkt(8'h00, 3, 6'h3E, 0, 0, 0);
        checkpoint("rd_wrap");
        ack_delay = -1;
        send_pkt(8'h01, 2, 6'h05, 0, 1, 1);
        checkpoint("wr_gaps");

        send_pkt(8'h01, 2, 6'h05, HDR_LEN+1, 0, 1);
        send_pkt(8'h01, 2, 6'h10, 0, 0, 1);
        checkpoint("abort");
        send_pkt(8'h16, 0, 6'h01, 0, 0, 0);
        send_pkt(8'h01, 1, 6'h20, 0, 0, 0);
        checkpoint("drop16");
        send_pkt(8'h01, 0, 6'h07, 0, 0, 0);
        checkpoint("wr_cnt0");
        send_pkt(8'h00, 0, 6'h07, 0, 0, 0);
        checkpoint("rd_cnt0");

        send_pkt(8'h01, 3, 6'h2A, HDR_LEN+6, 0, 0);
        checkpoint("pre_rst");
        do_reset();
        send_pkt(8'h01, 1, 6'h01, 0, 0, 0);
        checkpoint("post_rst");

        for (int p = 0; p < 150; p++) begin
            int sel, cnt, trunc;
            logic [7:0] typ;
            sel = int'($urandom_range(0, 9));
            typ = (sel < 5) ? 8'h01 : (sel < 8) ? 8'h00 :
                  (sel == 8) ? 8'h16 : 8'($urandom_range(2, 255));
            cnt = int'($urandom_range(0, 8));
            trunc = 0;
            if ($urandom_range(0, 3) == 0)
                trunc = (typ == 8'h01) ? int'($urandom_range(1, HDR_LEN + cnt*WB))
                                       : int'($urandom_range(1, HDR_LEN-1));
            if (!exp_busy && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) beat({1'b0, 8'($urandom)}, 0);
            send_pkt(typ, cnt, 6'($urandom), trunc, int'($urandom_range(0, 2)), 0);
            checkpoint("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/hcp_tsmp_parser.md
# hcp_tsmp_parser

Parametrised TSMP host-command parser for the CMC management path. It takes the 9-bit byte stream from the frame receiver, where bit 8 flags the first byte of a packet, and collects a configurable header. It decodes the packet type, then issues register-file write commands built from assembled payload words, or read requests with a ready/ack handshake. It adds abort-on-restart, drop of unknown types, and error reporting.

## Interface
- DATA_WIDTH, 9: input lane width; bit DATA_WIDTH-1 = start flag, bits 7:0 = byte
- HDR_LEN, 24: header length in bytes, including the start byte (≥4)
- TYPE_IDX, 1: header byte index of the packet type
- CNT_IDX, 18: header byte index of the word count (8 bits, words)
- ADDR_W, 6: register address width; base address = low ADDR_W bits of header byte HDR_LEN-1
- WORD_BYTES, 4: bytes per register word (1..4); word width = 8*WORD_BYTES
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- iv_data  in  DATA_WIDTH  stream byte plus start flag
- i_data_wr  in  1  iv_data valid this cycle
- o_wr  out  1  one-cycle register write strobe
- ov_wr_addr  out  ADDR_W  write address
- ov_wr_data  out  8*WORD_BYTES  write data
- o_rd_req  out  1  read request, held until acked
- ov_rd_addr  out  ADDR_W  read address
- i_rd_ack  in  1  read request accepted
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  one-cycle error pulse
- ov_err_cnt  out  16  error count (see Configuration)

## Operation
- Only cycles with i_data_wr=1 are beats. Non-beat cycles change nothing except the read handshake.
- States: IDLE, HDR, WRITE, READ, DROP.
- IDLE: a beat with the start flag set stores byte 0, sets hdr_cnt=1 and moves to HDR. Beats without the flag are ignored.
- HDR: each beat stores byte hdr_cnt. On byte HDR_LEN-1, latch type, count and base address, then:
  - type 8'h01: go to WRITE, or IDLE if count=0.
  - type 8'h00: go to READ, or IDLE if count=0.
  - any other type (incl. 8'h16, 8'hFF): go to DROP, with no o_err.
- WRITE: bytes are packed MSB-first into a word. When byte WORD_BYTES-1 of a word arrives, o_wr pulses with the word and the current address. The address then increments mod 2^ADDR_W and the count decrements. After the last word, go to IDLE.
- READ: o_rd_req=1 with ov_rd_addr. On i_rd_ack, increment the address and decrement the count; drop the request after the last ack and go to IDLE. Non-start beats in READ are ignored.
- DROP: ignore beats until a start-flag beat.
- Start flag in HDR, WRITE, READ or DROP:
  - From HDR, WRITE or READ: o_err pulses, any partial word is discarded, o_rd_req drops the same cycle, and the byte becomes byte 0 of a new header (state HDR, hdr_cnt=1).
  - From DROP: same restart, no o_err.
- Start flag in the same cycle as i_rd_ack: the ack is honoured (no further request), then the restart proceeds.
- Header bytes other than those at TYPE_IDX, CNT_IDX and HDR_LEN-1 are not retained.
- Reset values: all outputs 0, state IDLE, counters and address 0. Reset asserted mid-packet discards the packet with no o_err.

## Timing
- o_wr and its data/address are registered and assert the cycle after the beat carrying the last byte of a word.
- o_rd_req asserts the cycle after the last header beat. The next request is presented the cycle after the ack, so the minimum is 1 request per 2 cycles. With i_rd_ack held high, requests are accepted on alternate cycles only.
- o_busy is registered and follows the state.
- o_err asserts the cycle after the offending beat.

## Configuration
- HCP_PARSER_ERR_CNT_EN defined: ov_err_cnt increments on every o_err pulse, saturates at 16'hFFFF, and resets to 0.
- Not defined: ov_err_cnt is constant 0 and no counter logic is built. o_err is unaffected either way.

## Test plan
- Write packet, type 01, count 2, base 6'h05, payload 11 22 33 44 AA BB CC DD:
  - o_wr pulses at 05/32'h11223344 and 06/32'hAABBCCDD;
  - then IDLE, o_busy=0.
- Read packet, type 00, count 3, base 6'h3E; i_rd_ack returned 2 cycles after each request:
  - requests at 3E, 3F, 00 (wrap);
  - o_rd_req low after the third ack.
- Write packet with i_data_wr deasserted every other cycle: the same words and addresses as the contiguous case.
- Start flag on the 2nd payload byte of a write packet:
  - o_err pulses and no o_wr occurs;
  - the following complete packet is decoded correctly;
  - ov_err_cnt=1 with the macro, 0 without.
- Type 16 packet followed by a type 01 packet: no o_wr and no o_err for the first; correct writes for the second.
- Count 0 write and count 0 read: return to IDLE, no strobes. Reset asserted mid-WRITE: outputs 0, state IDLE, no o_err.
